ex_flag_stage: RTL and testbench

Execute-stage back end that consumes the ALU's 16-bit result and its 3-bit flag vector {V,N,Z}. It registers the result into the EX/MEM pipeline register and keeps the architectural flag register with per-opcode write masks. It also evaluates the 3-bit branch condition for the branch instruction sitting in decode. It sits directly downstream of the ALU and upstream of the memory stage and the branch/PC logic.

---
 rtl/ex_flag_stage.sv | 183 ++++++++++++++++++
 tb/tb_ex_flag_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flag_stage.sv
// ----------------------------------------------------------------------------
// ex_flag_stage
//
// Back end of the execute stage. Captures the ALU result into the EX/MEM
// pipeline register, maintains the architectural {V,N,Z} flag register with
// per-opcode write masks, and evaluates the condition of the branch that is
// currently in decode.
//
// Optional feature (compile-time macro):
//   FLAG_BYPASS_EN  - branch condition uses the flags being produced by the
//                     advancing EX instruction (zero-bubble flag forwarding).
//                     Without it the condition uses the registered flags only.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset (overrides stall/flush)
//   ex_valid    in   valid instruction in EX
//   ex_alu_op   in   EX instruction is an ALU opcode (flag-eligible)
//   ex_alu_opc  in   [2:0] ALU opcode
//   alu_out     in   [15:0] ALU result
//   alu_flags   in   [2:0] ALU flags {V,N,Z}
//   ex_dst      in   [3:0] destination register
//   ex_wr       in   instruction writes the register file
//   stall       in   hold EX/MEM register and flags
//   flush       in   kill the EX instruction (wins over stall)
//   br_check    in   decode holds a conditional branch
//   br_cond     in   [2:0] branch condition code
//   br_taken    out  branch condition satisfied (combinational)
//   mem_valid   out  EX/MEM valid
//   mem_result  out  [15:0] registered result
//   mem_dst     out  [3:0] registered destination
//   mem_wr      out  registered write enable (0 whenever mem_valid is 0)
//   flags       out  [2:0] architectural flag register {V,N,Z}
// ----------------------------------------------------------------------------
module ex_flag_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_alu_op,
    input  logic [2:0]  ex_alu_opc,
    input  logic [15:0] alu_out,
    input  logic [2:0]  alu_flags,
    input  logic [3:0]  ex_dst,
    input  logic        ex_wr,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_check,
    input  logic [2:0]  br_cond,
    output logic        br_taken,
    output logic        mem_valid,
    output logic [15:0] mem_result,
    output logic [3:0]  mem_dst,
    output logic        mem_wr,
    output logic [2:0]  flags
);

    // ALU opcodes
    localparam logic [2:0] OPC_ADD    = 3'b000;
    localparam logic [2:0] OPC_SUB    = 3'b001;
    localparam logic [2:0] OPC_XOR    = 3'b010;
    localparam logic [2:0] OPC_RED    = 3'b011;
    localparam logic [2:0] OPC_SLL    = 3'b100;
    localparam logic [2:0] OPC_SRA    = 3'b101;
    localparam logic [2:0] OPC_ROR    = 3'b110;
    localparam logic [2:0] OPC_PADDSB = 3'b111;

    // Branch condition codes
    localparam logic [2:0] CC_NE  = 3'b000;
    localparam logic [2:0] CC_EQ  = 3'b001;
    localparam logic [2:0] CC_GT  = 3'b010;
    localparam logic [2:0] CC_LT  = 3'b011;
    localparam logic [2:0] CC_GE  = 3'b100;
    localparam logic [2:0] CC_LE  = 3'b101;
    localparam logic [2:0] CC_OV  = 3'b110;
    localparam logic [2:0] CC_UNC = 3'b111;

    logic       advance;
    logic       flag_upd;
    logic       wr_z;
    logic       wr_nv;
    logic [2:0] flags_next;
    logic [2:0] eff_flags;
    logic       cond_met;
    logic       f_v;
    logic       f_n;
    logic       f_z;

    assign advance  = ex_valid & ~stall & ~flush;
    assign flag_upd = advance & ex_alu_op;

    // Per-opcode flag write mask. RED and PADDSB leave every flag alone;
    // logical/shift ops only define Z; only ADD/SUB define N and V.
    always_comb begin
        wr_z  = 1'b0;
        wr_nv = 1'b0;
        case (ex_alu_opc)
            OPC_ADD, OPC_SUB: begin
                wr_z  = 1'b1;
                wr_nv = 1'b1;
            end
            OPC_XOR, OPC_SLL, OPC_SRA, OPC_ROR: begin
                wr_z  = 1'b1;
            end
            OPC_RED, OPC_PADDSB: begin
                wr_z  = 1'b0;
            end
            default: begin
                wr_z  = 1'b0;
            end
        endcase
    end

    // Masked merge: unwritten bits keep the current register value.
    always_comb begin
        flags_next = flags;
        if (flag_upd) begin
            if (wr_nv) begin
                flags_next[2:1] = alu_flags[2:1];
            end
            if (wr_z) begin
                flags_next[0] = alu_flags[0];
            end
        end
    end

`ifdef FLAG_BYPASS_EN
    // Forward the advancing instruction's flags so a dependent branch in
    // decode needs no bubble. A stalled or flushed instruction is not
    // forwarded because it does not commit this cycle.
    assign eff_flags = flag_upd ? flags_next : flags;
`else
    assign eff_flags = flags;
`endif

    assign f_v = eff_flags[2];
    assign f_n = eff_flags[1];
    assign f_z = eff_flags[0];

    always_comb begin
        cond_met = 1'b0;
        case (br_cond)
            CC_NE:   cond_met = ~f_z;
            CC_EQ:   cond_met = f_z;
            CC_GT:   cond_met = ~f_z & ~f_n;
            CC_LT:   cond_met = f_n;
            CC_GE:   cond_met = f_z | (~f_z & ~f_n);
            CC_LE:   cond_met = f_n | f_z;
            CC_OV:   cond_met = f_v;
            CC_UNC:  cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    end

    assign br_taken = br_check & cond_met;

    // EX/MEM register and flag register. Flush clears only the control
    // bits; the data fields are left as they were since nothing consumes
    // them while mem_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_wr     <= 1'b0;
            mem_result <= 16'h0000;
            mem_dst    <= 4'h0;
            flags      <= 3'b000;
        end else begin
            if (flush) begin
                mem_valid <= 1'b0;
                mem_wr    <= 1'b0;
            end else if (!stall) begin
                mem_valid  <= ex_valid;
                mem_result <= alu_out;
                mem_dst    <= ex_dst;
                mem_wr     <= ex_wr & ex_valid;
            end

            if (!stall && !flush) begin
                flags <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_ex_flag_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_flag_stage
//
// Directed bench for ex_flag_stage. Inputs change only on the falling edge.
// Each driven cycle pushes the hand-computed register state expected after
// the next rising edge; a monitor pops and compares it just after that edge.
// br_taken is combinational and is compared shortly after inputs settle.
// ----------------------------------------------------------------------------
module tb_ex_flag_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_alu_op;
    logic [2:0]  ex_alu_opc;
    logic [15:0] alu_out;
    logic [2:0]  alu_flags;
    logic [3:0]  ex_dst;
    logic        ex_wr;
    logic        stall;
    logic        flush;
    logic        br_check;
    logic [2:0]  br_cond;
    logic        br_taken;
    logic        mem_valid;
    logic [15:0] mem_result;
    logic [3:0]  mem_dst;
    logic        mem_wr;
    logic [2:0]  flags;

`ifdef FLAG_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    localparam int W = 25;  // {mem_valid, mem_result, mem_dst, mem_wr, flags}

    logic [W-1:0] exp_q[$];
    int total;
    int bad;

    ex_flag_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_alu_op  (ex_alu_op),
        .ex_alu_opc (ex_alu_opc),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .ex_dst     (ex_dst),
        .ex_wr      (ex_wr),
        .stall      (stall),
        .flush      (flush),
        .br_check   (br_check),
        .br_cond    (br_cond),
        .br_taken   (br_taken),
        .mem_valid  (mem_valid),
        .mem_result (mem_result),
        .mem_dst    (mem_dst),
        .mem_wr     (mem_wr),
        .flags      (flags)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] st(input logic v, input logic [15:0] r,
                                        input logic [3:0] d, input logic w,
                                        input logic [2:0] f);
        return {v, r, d, w, f};
    endfunction

    task automatic set_ex(input logic v, input logic aop, input logic [2:0] opc,
                          input logic [15:0] res, input logic [2:0] fl,
                          input logic [3:0] dst, input logic wr);
        ex_valid   = v;
        ex_alu_op  = aop;
        ex_alu_opc = opc;
        alu_out    = res;
        alu_flags  = fl;
        ex_dst     = dst;
        ex_wr      = wr;
    endtask

    task automatic set_ctl(input logic stl, input logic fls,
                           input logic bchk, input logic [2:0] bcond);
        stall    = stl;
        flush    = fls;
        br_check = bchk;
        br_cond  = bcond;
    endtask

    // Called at a falling edge after inputs are set: checks br_taken, queues
    // the expected post-edge state, then advances to the next falling edge.
    task automatic cyc(input logic exp_bt, input logic [W-1:0] exp_state);
        #1;
        total++;
        if (br_taken !== exp_bt) begin
            bad++;
            $display("FAIL br_taken t=%0t chk=%b cond=%0d got=%b exp=%b",
                     $time, br_check, br_cond, br_taken, exp_bt);
        end
        exp_q.push_back(exp_state);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {mem_valid, mem_result, mem_dst, mem_wr, flags};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL regs t=%0t got v=%b res=%h dst=%h wr=%b fl=%b exp v=%b res=%h dst=%h wr=%b fl=%b",
                         $time, got[24], got[23:8], got[7:4], got[3], got[2:0],
                         e[24], e[23:8], e[7:4], e[3], e[2:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] pat;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_ex(1'b1, 1'b1, 3'd0, 16'hBEEF, 3'b111, 4'hF, 1'b1);
        set_ctl(1'b1, 1'b1, 1'b0, 3'd0);
        @(negedge clk);

        // reset with stall and flush asserted
        cyc(1'b0, st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b000));
        cyc(1'b0, st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b000));
        rst = 1'b0;

        // SUB result zero, concurrent EQ branch (bypass-dependent)
        set_ex(1'b1, 1'b1, 3'd1, 16'h0000, 3'b001, 4'h3, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b1, 3'd1);
        cyc(BYP, st(1'b1, 16'h0000, 4'h3, 1'b1, 3'b001));

        // RED writes no flag; EQ now true from registered flags
        set_ex(1'b1, 1'b1, 3'd3, 16'h1234, 3'b000, 4'h4, 1'b1);
        cyc(1'b1, st(1'b1, 16'h1234, 4'h4, 1'b1, 3'b001));

        // XOR clears Z only
        set_ex(1'b1, 1'b1, 3'd2, 16'h00FF, 3'b000, 4'h5, 1'b0);
        set_ctl(1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, st(1'b1, 16'h00FF, 4'h5, 1'b0, 3'b000));

        // ADD writes V and N
        set_ex(1'b1, 1'b1, 3'd0, 16'h8000, 3'b110, 4'h6, 1'b1);
        cyc(1'b0, st(1'b1, 16'h8000, 4'h6, 1'b1, 3'b110));

        // SLL sets Z, N/V retained
        set_ex(1'b1, 1'b1, 3'd4, 16'h0000, 3'b001, 4'h7, 1'b1);
        cyc(1'b0, st(1'b1, 16'h0000, 4'h7, 1'b1, 3'b111));

        // SRA with N=0 from ALU: only Z taken, N stays 1
        set_ex(1'b1, 1'b1, 3'd5, 16'hFFFF, 3'b000, 4'h8, 1'b1);
        cyc(1'b0, st(1'b1, 16'hFFFF, 4'h8, 1'b1, 3'b110));

        // PADDSB writes no flag
        set_ex(1'b1, 1'b1, 3'd7, 16'h0101, 3'b001, 4'h9, 1'b1);
        cyc(1'b0, st(1'b1, 16'h0101, 4'h9, 1'b1, 3'b110));

        // ROR sets Z
        set_ex(1'b1, 1'b1, 3'd6, 16'hABCD, 3'b001, 4'hA, 1'b1);
        cyc(1'b0, st(1'b1, 16'hABCD, 4'hA, 1'b1, 3'b111));

        // non-ALU instruction leaves flags alone
        set_ex(1'b1, 1'b0, 3'd0, 16'h5555, 3'b000, 4'hB, 1'b1);
        cyc(1'b0, st(1'b1, 16'h5555, 4'hB, 1'b1, 3'b111));

        // bubble: mem_valid=0, mem_wr forced 0, data still captured
        set_ex(1'b0, 1'b1, 3'd0, 16'h9999, 3'b000, 4'hC, 1'b1);
        cyc(1'b0, st(1'b0, 16'h9999, 4'hC, 1'b0, 3'b111));

        // ADD held by stall for 3 cycles, then commits
        set_ex(1'b1, 1'b1, 3'd0, 16'h7FFF, 3'b100, 4'h1, 1'b1);
        set_ctl(1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, st(1'b0, 16'h9999, 4'hC, 1'b0, 3'b111));
        end
        set_ctl(1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, st(1'b1, 16'h7FFF, 4'h1, 1'b1, 3'b100));

        // stall and flush together: flush wins, flags untouched
        set_ex(1'b1, 1'b1, 3'd0, 16'h1111, 3'b011, 4'h2, 1'b1);
        set_ctl(1'b1, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, st(1'b0, 16'h7FFF, 4'h1, 1'b0, 3'b100));

        // flushed ADD with concurrent EQ branch: registered flags used
        set_ex(1'b1, 1'b1, 3'd0, 16'h2222, 3'b110, 4'h2, 1'b1);
        set_ctl(1'b0, 1'b1, 1'b1, 3'd1);
        cyc(1'b0, st(1'b0, 16'h7FFF, 4'h1, 1'b0, 3'b100));
        set_ex(1'b1, 1'b1, 3'd0, 16'h2222, 3'b001, 4'h2, 1'b1);
        cyc(1'b0, st(1'b0, 16'h7FFF, 4'h1, 1'b0, 3'b100));

        // SUB sets N; concurrent LT branch is bypass-dependent
        set_ex(1'b1, 1'b1, 3'd1, 16'hFFFE, 3'b010, 4'hE, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b1, 3'd3);
        cyc(BYP, st(1'b1, 16'hFFFE, 4'hE, 1'b1, 3'b010));

        // stalled ADD must not be forwarded to an EQ branch
        set_ex(1'b1, 1'b1, 3'd0, 16'h0000, 3'b001, 4'hD, 1'b1);
        set_ctl(1'b1, 1'b0, 1'b1, 3'd1);
        cyc(1'b0, st(1'b1, 16'hFFFE, 4'hE, 1'b1, 3'b010));
        cyc(1'b0, st(1'b1, 16'hFFFE, 4'hE, 1'b1, 3'b010));

        // condition sweep with flags=010
        pat = 8'b1010_1001;
        set_ex(1'b0, 1'b0, 3'd0, 16'h0000, 3'b000, 4'h0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            set_ctl(1'b0, 1'b0, 1'b1, 3'(c));
            cyc(pat[c], st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b010));
        end
        for (int c = 0; c < 8; c++) begin
            set_ctl(1'b0, 1'b0, 1'b0, 3'(c));
            cyc(1'b0, st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b010));
        end

        // load something, then reset mid-operation
        set_ex(1'b1, 1'b1, 3'd0, 16'h4242, 3'b011, 4'h9, 1'b1);
        set_ctl(1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, st(1'b1, 16'h4242, 4'h9, 1'b1, 3'b011));
        rst = 1'b1;
        set_ex(1'b1, 1'b1, 3'd0, 16'h4343, 3'b111, 4'h8, 1'b1);
        cyc(1'b0, st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b000));
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 3'd0, 16'h0000, 3'b000, 4'h0, 1'b0);
        cyc(1'b0, st(1'b0, 16'h0000, 4'h0, 1'b0, 3'b000));

        // every queued expectation must have been consumed
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending exp=0 pending", exp_q.size());
        end

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
